// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward-select codes,
// Tuse/Tnew values, md start kinds and the shadow slot record.
package hazard_fwd_ctrl_pkg;

  localparam logic [2:0] FW_RF   = 3'd0;
  localparam logic [2:0] FW_OWN  = 3'd0;
  localparam logic [2:0] FW_W    = 3'd1;
  localparam logic [2:0] FW_M    = 3'd2;
  localparam logic [2:0] FW_PCA8 = 3'd3;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10
  } mdStart_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       link;
  } slot_t;

  // One stage of ageing: the result is one cycle closer, never below zero.
  function automatic logic [1:0] tnewAge(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_slot.sv
// One shadow pipeline slot: registers {valid, dst, tnew, link}, optionally ages
// tnew on load, and matches a set of source addresses against its destination.
module hazard_stage_slot
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int N_MATCH  = 2,
  parameter bit AGE_TNEW = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  slot_t                   slotNext,
  output slot_t                   slotQ,
  input  logic [N_MATCH-1:0][4:0] matchAddr,
  output logic [N_MATCH-1:0]      matchHit
);

  slot_t slotLoad;

  always_comb begin
    slotLoad = slotNext;
    if (AGE_TNEW) slotLoad.tnew = tnewAge(slotNext.tnew);
  end

  always_ff @(posedge clk) begin
    if (reset) slotQ <= '0;
    else       slotQ <= slotLoad;
  end

  // Register 0 never produces a hazard, so a zero address or zero dst never hits.
  always_comb begin
    matchHit = '0;
    for (int i = 0; i < N_MATCH; i++)
      matchHit[i] = (matchAddr[i] != 5'd0) && slotQ.valid && (slotQ.dst == matchAddr[i]);
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: shadow E/M/W destination state drives the D-stage
// stall, the compare/ALU/store forwarding selects and the mult/div interlock.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_link,
  input  logic [1:0] d_md_start,
  input  logic       d_md_use,
  output logic       stall,
  output logic [2:0] fw_cmp_rs,
  output logic [2:0] fw_cmp_rt,
  output logic [2:0] fw_alu_rs,
  output logic [2:0] fw_alu_rt,
  output logic [2:0] fw_dm_rt,
  output logic       md_busy
);

  slot_t      eNext, eSlot, mSlot, wSlot;
  logic [4:0] eRs, eRt, mRt;
  mdStart_e   eMd;
  logic [3:0] mdCnt;
  logic [1:0] eHit;   // d_rs, d_rt
  logic [3:0] mHit;   // d_rs, d_rt, eRs, eRt
  logic [4:0] wHit;   // d_rs, d_rt, eRs, eRt, mRt
  logic       mReady;
  logic       mdAccept;
  logic       wSlotUnused;

  assign eNext = stall ? '0 : {1'b1, d_dst, d_tnew, d_link};

  hazard_stage_slot #(.N_MATCH(2), .AGE_TNEW(1'b0)) uSlotE (
    .clk(clk), .reset(reset), .slotNext(eNext), .slotQ(eSlot),
    .matchAddr({d_rt, d_rs}), .matchHit(eHit)
  );

  hazard_stage_slot #(.N_MATCH(4), .AGE_TNEW(1'b1)) uSlotM (
    .clk(clk), .reset(reset), .slotNext(eSlot), .slotQ(mSlot),
    .matchAddr({eRt, eRs, d_rt, d_rs}), .matchHit(mHit)
  );

  hazard_stage_slot #(.N_MATCH(5), .AGE_TNEW(1'b0)) uSlotW (
    .clk(clk), .reset(reset), .slotNext(mSlot), .slotQ(wSlot),
    .matchAddr({mRt, eRt, eRs, d_rt, d_rs}), .matchHit(wHit)
  );

  // W only matters through its match outputs.
  assign wSlotUnused = ^wSlot;

  assign mdAccept = !stall && (d_md_start != MD_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      eRs   <= '0;
      eRt   <= '0;
      mRt   <= '0;
      eMd   <= MD_NONE;
      mdCnt <= '0;
    end else begin
      eRs <= stall ? 5'd0 : d_rs;
      eRt <= stall ? 5'd0 : d_rt;
      eMd <= stall ? MD_NONE : mdStart_e'(d_md_start);
      mRt <= eRt;
      if (mdAccept)
        mdCnt <= (d_md_start == MD_DIV) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      else if (mdCnt != 4'd0)
        mdCnt <= mdCnt - 4'd1;
    end
  end

  assign md_busy = (mdCnt != 4'd0) || (eSlot.valid && (eMd != MD_NONE));
  assign mReady  = (mSlot.tnew == 2'd0);

  // A link in E carries tnew 0, so it can never exceed any Tuse.
  always_comb begin
    stall = 1'b0;
    if (eHit[0] && (eSlot.tnew > d_tuse_rs)) stall = 1'b1;
    if (mHit[0] && (mSlot.tnew > d_tuse_rs)) stall = 1'b1;
    if (eHit[1] && (eSlot.tnew > d_tuse_rt)) stall = 1'b1;
    if (mHit[1] && (mSlot.tnew > d_tuse_rt)) stall = 1'b1;
    if (d_md_use && md_busy)                 stall = 1'b1;
  end

  always_comb begin
    fw_cmp_rs = FW_RF;
    fw_cmp_rt = FW_RF;
    fw_alu_rs = FW_OWN;
    fw_alu_rt = FW_OWN;
    fw_dm_rt  = FW_OWN;

    if (eHit[0] && eSlot.link)  fw_cmp_rs = FW_PCA8;
    else if (mHit[0] && mReady) fw_cmp_rs = FW_M;
    else if (wHit[0])           fw_cmp_rs = FW_W;

    if (eHit[1] && eSlot.link)  fw_cmp_rt = FW_PCA8;
    else if (mHit[1] && mReady) fw_cmp_rt = FW_M;
    else if (wHit[1])           fw_cmp_rt = FW_W;

    if (mHit[2] && mReady)      fw_alu_rs = FW_M;
    else if (wHit[2])           fw_alu_rs = FW_W;

    if (mHit[3] && mReady)      fw_alu_rt = FW_M;
    else if (wHit[3])           fw_alu_rt = FW_W;

    if (wHit[4])                fw_dm_rt  = FW_W;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: per-cycle D stimulus with hand-derived
// expectations queued at drive time and compared half a cycle later.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_start;
  logic       d_link, d_md_use;
  logic       stall, md_busy;
  logic [2:0] fw_cmp_rs, fw_cmp_rt, fw_alu_rs, fw_alu_rt, fw_dm_rt;

  hazard_fwd_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_link(d_link),
    .d_md_start(d_md_start), .d_md_use(d_md_use),
    .stall(stall), .fw_cmp_rs(fw_cmp_rs), .fw_cmp_rt(fw_cmp_rt),
    .fw_alu_rs(fw_alu_rs), .fw_alu_rt(fw_alu_rt), .fw_dm_rt(fw_dm_rt),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuseRs;
    logic [1:0] tuseRt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       link;
    mdStart_e   md;
    logic       mdUse;
  } dIn_t;

  typedef struct {
    string      tag;
    logic       stall;
    logic [2:0] cmpRs, cmpRt, aluRs, aluRt, dmRt;
    logic       busy;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic dIn_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] tRs, input logic [1:0] tRt,
                              input logic [4:0] dst, input logic [1:0] tnew,
                              input logic link, input mdStart_e md, input logic mdUse);
    dIn_t d;
    d.rs = rs; d.rt = rt; d.tuseRs = tRs; d.tuseRt = tRt;
    d.dst = dst; d.tnew = tnew; d.link = link; d.md = md; d.mdUse = mdUse;
    return d;
  endfunction

  function automatic dIn_t dNop();
    return mk(0, 0, TUSE_NONE, TUSE_NONE, 0, TNEW_ALU, 1'b0, MD_NONE, 1'b0);
  endfunction
  function automatic dIn_t dAlu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, TUSE_E, TUSE_E, dst, TNEW_ALU, 1'b0, MD_NONE, 1'b0);
  endfunction
  function automatic dIn_t dLw(input logic [4:0] dst, input logic [4:0] rs);
    return mk(rs, 0, TUSE_E, TUSE_NONE, dst, TNEW_LOAD, 1'b0, MD_NONE, 1'b0);
  endfunction
  function automatic dIn_t dBeq(input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, TUSE_D, TUSE_D, 0, TNEW_ALU, 1'b0, MD_NONE, 1'b0);
  endfunction
  function automatic dIn_t dJal();
    return mk(0, 0, TUSE_NONE, TUSE_NONE, 5'd31, TNEW_LINK, 1'b1, MD_NONE, 1'b0);
  endfunction
  function automatic dIn_t dSw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, TUSE_E, TUSE_M, 0, TNEW_ALU, 1'b0, MD_NONE, 1'b0);
  endfunction
  function automatic dIn_t dMd(input logic [4:0] rs, input logic [4:0] rt, input mdStart_e kind);
    return mk(rs, rt, TUSE_E, TUSE_E, 0, TNEW_ALU, 1'b0, kind, 1'b1);
  endfunction
  function automatic dIn_t dMfhi(input logic [4:0] dst);
    return mk(0, 0, TUSE_NONE, TUSE_NONE, dst, TNEW_ALU, 1'b0, MD_NONE, 1'b1);
  endfunction

  function automatic exp_t ex(input string tag, input logic st,
                              input logic [2:0] cRs, input logic [2:0] cRt,
                              input logic [2:0] aRs, input logic [2:0] aRt,
                              input logic [2:0] dm, input logic bz);
    exp_t e;
    e.tag = tag; e.stall = st; e.cmpRs = cRs; e.cmpRt = cRt;
    e.aluRs = aRs; e.aluRt = aRt; e.dmRt = dm; e.busy = bz;
    return e;
  endfunction
  function automatic exp_t exZ(input string tag);
    return ex(tag, 1'b0, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 1'b0);
  endfunction

  task automatic applyD(input dIn_t d);
    d_rs = d.rs; d_rt = d.rt; d_tuse_rs = d.tuseRs; d_tuse_rt = d.tuseRt;
    d_dst = d.dst; d_tnew = d.tnew; d_link = d.link;
    d_md_start = d.md; d_md_use = d.mdUse;
  endtask

  task automatic compareOut();
    exp_t e;
    e = expQ.pop_front();
    checkVal({e.tag, ".stall"},     8'(stall),     8'(e.stall));
    checkVal({e.tag, ".fw_cmp_rs"}, 8'(fw_cmp_rs), 8'(e.cmpRs));
    checkVal({e.tag, ".fw_cmp_rt"}, 8'(fw_cmp_rt), 8'(e.cmpRt));
    checkVal({e.tag, ".fw_alu_rs"}, 8'(fw_alu_rs), 8'(e.aluRs));
    checkVal({e.tag, ".fw_alu_rt"}, 8'(fw_alu_rt), 8'(e.aluRt));
    checkVal({e.tag, ".fw_dm_rt"},  8'(fw_dm_rt),  8'(e.dmRt));
    checkVal({e.tag, ".md_busy"},   8'(md_busy),   8'(e.busy));
  endtask

  // Called at posedge+1: drive D, queue the expectation, check at negedge.
  task automatic cyc(input dIn_t d, input exp_t e);
    applyD(d);
    expQ.push_back(e);
    @(negedge clk);
    compareOut();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      applyD(dNop());
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    applyD(dNop());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    cyc(dMfhi(5'd3), exZ("rst0"));
    flush();

    // addu $1 ; beq $1,$2
    cyc(dAlu(1, 2, 3), exZ("t1c0"));
    cyc(dBeq(1, 2),    ex("t1c1", 1, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dBeq(1, 2),    ex("t1c2", 0, FW_M,  FW_RF, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dNop(),        ex("t1c3", 0, FW_RF, FW_RF, FW_W,   FW_OWN, FW_OWN, 0));
    cyc(dNop(),        exZ("t1c4"));
    flush();

    // lw $3 ; addu $4,$3,$0
    cyc(dLw(3, 0),     exZ("t2c0"));
    cyc(dAlu(4, 3, 0), ex("t2c1", 1, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dAlu(4, 3, 0), exZ("t2c2"));
    cyc(dNop(),        ex("t2c3", 0, FW_RF, FW_RF, FW_W, FW_OWN, FW_OWN, 0));
    cyc(dNop(),        exZ("t2c4"));
    flush();

    // jal ; beq $31 ; jal ; beq $0 ; beq $0,$31 ; beq $31 from W
    cyc(dJal(),         exZ("t3c0"));
    cyc(dBeq(31, 0),    ex("t3c1", 0, FW_PCA8, FW_RF, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dJal(),         ex("t3c2", 0, FW_RF, FW_RF, FW_M, FW_OWN, FW_OWN, 0));
    cyc(dBeq(0, 0),     exZ("t3c3"));
    cyc(dBeq(0, 31),    ex("t3c4", 0, FW_RF, FW_M, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dBeq(31, 0),    ex("t3c5", 0, FW_W, FW_RF, FW_OWN, FW_W, FW_OWN, 0));
    cyc(dNop(),         exZ("t3c6"));
    flush();

    // addu $5 ; sw $5,0($0)
    cyc(dAlu(5, 0, 0), exZ("t4c0"));
    cyc(dSw(0, 5),     exZ("t4c1"));
    cyc(dNop(),        ex("t4c2", 0, FW_RF, FW_RF, FW_OWN, FW_M, FW_OWN, 0));
    cyc(dNop(),        ex("t4c3", 0, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_W, 0));
    cyc(dNop(),        exZ("t4c4"));
    flush();

    // M beats W when both hold the same destination
    cyc(dAlu(6, 0, 0), exZ("t7c0"));
    cyc(dAlu(6, 0, 0), exZ("t7c1"));
    cyc(dAlu(7, 6, 6), ex("t7c2", 0, FW_M, FW_M, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dNop(),        ex("t7c3", 0, FW_RF, FW_RF, FW_M, FW_M, FW_OWN, 0));
    cyc(dNop(),        ex("t7c4", 0, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_W, 0));
    flush();

    // div ; mfhi
    cyc(dMd(3, 4, MD_DIV), exZ("t5dc0"));
    for (int i = 0; i < DIV_N; i++)
      cyc(dMfhi(6), ex($sformatf("t5dw%0d", i), 1, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 1));
    cyc(dMfhi(6), exZ("t5drel"));
    cyc(dNop(),   exZ("t5dend"));
    flush();

    // lw $1 ; mult $1,$2 (load stall holds the start back) ; mfhi
    cyc(dLw(1, 0),          exZ("t5mc0"));
    cyc(dMd(1, 2, MD_MULT), ex("t5mc1", 1, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 0));
    cyc(dMd(1, 2, MD_MULT), exZ("t5mc2"));
    cyc(dMfhi(7),           ex("t5mc3", 1, FW_RF, FW_RF, FW_W, FW_OWN, FW_OWN, 1));
    for (int i = 1; i < MULT_N; i++)
      cyc(dMfhi(7), ex($sformatf("t5mw%0d", i), 1, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 1));
    cyc(dMfhi(7), exZ("t5mrel"));
    cyc(dNop(),   exZ("t5mend"));
    flush();

    // reset in the middle of a div with live E/M slots
    cyc(dMd(1, 2, MD_DIV),  exZ("t6c0"));
    cyc(dNop(),             ex("t6c1", 0, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 1));
    cyc(dAlu(10, 0, 0),     ex("t6c2", 0, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 1));
    cyc(dAlu(8, 10, 0),     ex("t6c3", 0, FW_RF, FW_RF, FW_OWN, FW_OWN, FW_OWN, 1));
    reset = 1'b1;
    cyc(dAlu(9, 8, 8),      ex("t6c4", 0, FW_RF, FW_RF, FW_M, FW_OWN, FW_OWN, 1));
    reset = 1'b0;
    cyc(mk(8, 10, TUSE_D, TUSE_D, 0, TNEW_ALU, 1'b0, MD_NONE, 1'b1), exZ("t6post"));
    cyc(dNop(),             exZ("t6post2"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
